// File: rtl/control_sequencer_if.sv
// Handshake bundle between the core control plane and the instruction sequencer.
// The sequencer sits on the slave side; whoever drives run control and decoder/data-mover flags is the master.
interface control_sequencer_if #(
    parameter int CNT_W = 32
);
    // Handshake semantics: the sequencer has no ready/valid pairs.
    // - step is a one-cycle request, consumed only in IDLE with step_mode=1.
    // - halt/func are treated as valid only in DECODE.
    // - mem_done is a completion strobe, consumed only in MEM.
    // - All inputs are ignored outside those states and are never queued.
    logic             en;
    logic             step_mode;
    logic             step;
    logic             stall;
    logic             halt;
    logic [2:0]       func;
    logic             mem_done;
    logic [8:0]       state;
    logic             busy;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] retired;

    modport master (
        output en, step_mode, step, stall, halt, func, mem_done,
        input  state, busy, halted, fault, retired
    );

    modport slave (
        input  en, step_mode, step, stall, halt, func, mem_done,
        output state, busy, halted, fault, retired
    );
endinterface

// File: rtl/control_sequencer.sv
// One-hot multi-cycle instruction sequencer: fetch latency, bounded MEM wait with fault,
// global stall, single-step mode and a retired-instruction counter.
module control_sequencer #(
    parameter int FETCH_LAT   = 1,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    control_sequencer_if.slave bus
);
    typedef enum logic [8:0] {
        IDLE      = 9'b000000001,
        FETCH     = 9'b000000010,
        DECODE    = 9'b000000100,
        EXEC_ALU  = 9'b000001000,
        MEM       = 9'b000010000,
        BRANCH    = 9'b000100000,
        FAULT     = 9'b001000000,
        PC_UPDATE = 9'b010000000,
        HALT      = 9'b100000000
    } state_e;

    localparam logic [3:0] FETCH_LAST = 4'(FETCH_LAT - 1);
    localparam logic [7:0] MEM_LAST   = 8'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [3:0]       fetch_cnt_q, fetch_cnt_d;
    logic [7:0]       mem_cnt_q, mem_cnt_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             busy_q, busy_d;
    logic             frozen;

    // Stall only freezes instruction-executing states; IDLE/HALT/FAULT ignore it.
    assign frozen = bus.stall && !(state_q inside {IDLE, HALT, FAULT});

    always_comb begin
        state_d     = state_q;
        fetch_cnt_d = fetch_cnt_q;
        mem_cnt_d   = mem_cnt_q;
        retired_d   = retired_q;
        if (!frozen) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.en && (!bus.step_mode || bus.step)) begin
                        state_d     = FETCH;
                        fetch_cnt_d = '0;
                    end
                end
                FETCH: begin
                    if (fetch_cnt_q == FETCH_LAST) state_d = DECODE;
                    else fetch_cnt_d = fetch_cnt_q + 4'd1;
                end
                DECODE: begin
                    if (bus.halt) begin
                        state_d = HALT;
                    end else begin
                        case (bus.func)
                            3'b000:  state_d = EXEC_ALU;
                            3'b001: begin
                                state_d   = MEM;
                                mem_cnt_d = '0;
                            end
                            3'b010:  state_d = BRANCH;
                            default: state_d = FAULT;
                        endcase
                    end
                end
                EXEC_ALU, BRANCH: state_d = PC_UPDATE;
                MEM: begin
                    // mem_done in the final allowed cycle still wins over the timeout.
                    mem_cnt_d = mem_cnt_q + 8'd1;
                    if (bus.mem_done)             state_d = PC_UPDATE;
                    else if (mem_cnt_q == MEM_LAST) state_d = FAULT;
                end
                PC_UPDATE: begin
                    retired_d   = retired_q + CNT_W'(1);
                    fetch_cnt_d = '0;
                    state_d     = (bus.en && !bus.step_mode) ? FETCH : IDLE;
                end
                HALT, FAULT: state_d = state_q;
                default:     state_d = IDLE;
            endcase
        end
        busy_d = !(state_d inside {IDLE, HALT, FAULT});
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            fetch_cnt_q <= '0;
            mem_cnt_q   <= '0;
            retired_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_cnt_q <= fetch_cnt_d;
            mem_cnt_q   <= mem_cnt_d;
            retired_q   <= retired_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.state   = state_q;
    assign bus.busy    = busy_q;
    assign bus.halted  = state_q[8];
    assign bus.fault   = state_q[6];
    assign bus.retired = retired_q;
endmodule
